bcd_gray_sched: RTL
===================

BCD_GRAY_SCHED -- requirements
Module: bcd_gray_sched

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of BCD digits per word (NDIG >= 1).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 has a word pending.
REQ-005 SHALL have port req0_bcd, input, 4*NDIG bits: requester 0 BCD word; digit i occupies bits [4i+3:4i], and digit 0 is least significant.
REQ-006 SHALL have port req0_ready, output, 1 bit: requester 0 word accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_bcd and req1_ready, identical to REQ-004 to REQ-006, for requester 1.
REQ-008 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-009 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-010 SHALL have port rsp_gray, output, 4*NDIG bits: per-digit Gray result, in the same digit layout as the request.
REQ-011 SHALL have port rsp_id, output, 1 bit: index of the requester that owns the response.
REQ-012 SHALL have port rsp_err, output, 1 bit: at least one input digit was greater than 9.

Function
REQ-013 SHALL convert each digit b[3:0] to g[3]=b[3], g[2]=b[3]^b[2], g[1]=b[2]^b[1], g[0]=b[1]^b[0].
REQ-014 SHALL use one shared digit converter, time-multiplexed one digit per cycle; no parallel converters.
REQ-015 SHALL implement an FSM with states IDLE, CONV and RESP.
REQ-016 In IDLE, when any valid is high, SHALL grant one requester: assert its ready combinationally that cycle, capture its word and id at the clock edge, and go to CONV.
REQ-017 SHALL arbitrate round-robin with a 1-bit priority pointer: if both valids are high, the pointed requester wins; after every grant the pointer moves to the other requester; if only one is valid, that one wins.
REQ-018 In CONV, SHALL process digit NDIG-1 first, down to digit 0, one per cycle, writing each result into the rsp_gray register; after NDIG cycles SHALL go to RESP.
REQ-019 SHALL latch rsp_err sticky within a transaction if any digit exceeds 9; digits 10-15 are still converted per REQ-013; rsp_err SHALL be cleared on each new grant.
REQ-020 In RESP, SHALL hold rsp_valid=1 with rsp_gray, rsp_id and rsp_err stable until rsp_valid&&rsp_ready; SHALL then go to IDLE.
REQ-021 Latency: with the accept handshake at edge E, rsp_valid SHALL be first high in the cycle following edge E+NDIG.
REQ-022 req0_ready and req1_ready SHALL be 0 outside IDLE, never both 1, and never 1 unless the matching valid is 1.
REQ-023 Requesters SHALL hold valid and data stable until ready; the block samples data only in the handshake cycle.
REQ-024 Maximum throughput SHALL be one word per NDIG+2 cycles; a new grant SHALL NOT occur in the same cycle as the response handshake.

Reset
REQ-025 When rst=1 at an edge, SHALL set state=IDLE, pointer=requester 0, rsp_valid=0, rsp_gray=0, rsp_id=0, rsp_err=0 and digit counter=NDIG-1.
REQ-026 Reset during CONV or RESP SHALL abandon the transaction with no response emitted; readies SHALL be 0 while rst=1.

Structure
REQ-027 Package bcd_gray_pkg SHALL hold the FSM state typedef and the constants DIGIT_W=4 and BCD_MAX=9.
REQ-028 The per-digit converter SHALL be the combinational sub-module bcd_gray_digit (4-bit in, 4-bit out, plus an over-9 flag), instantiated once.

Verification
REQ-029 NDIG=4; req0 only, bcd=0x1239 -> rsp_gray=0x132D, rsp_id=0, rsp_err=0; rsp_valid high in the 5th cycle after accept.
REQ-030 After reset, req0=0x1239 and req1=0x0987 both valid -> req0 served first (0x132D), then req1 (0x0DC4, id=1).
REQ-031 req1 bcd=0x12A4 -> rsp_gray=0x13F6, rsp_err=1; the next clean word -> rsp_err=0.
REQ-032 rsp_ready held low 10 cycles in RESP -> outputs stable, both readies 0; one cycle after rsp_ready=1 the block is back in IDLE.
REQ-033 Both valids held continuously -> grants alternate 0,1,0,1; rst pulsed mid-CONV -> no rsp_valid, pointer resets to 0, next word correct.

Source files
------------

// File: rtl/bcd_gray_pkg.sv
// Shared types and constants for the BCD-to-Gray request scheduler.
package bcd_gray_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_gray_digit.sv
// Combinational single-digit converter: 4-bit BCD digit to 4-bit Gray, plus an over-9 flag.
module bcd_gray_digit
  import bcd_gray_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [DIGIT_W-1:0] gray_o,
  output logic               over9_o
);

  assign gray_o  = {bcd_i[3], bcd_i[3] ^ bcd_i[2], bcd_i[2] ^ bcd_i[1], bcd_i[1] ^ bcd_i[0]};
  assign over9_o = (bcd_i > DIGIT_W'(BCD_MAX));

endmodule

// File: rtl/bcd_gray_sched.sv
// Two-requester round-robin scheduler feeding one shared BCD-to-Gray digit converter,
// one digit per cycle from the most significant digit down.
module bcd_gray_sched
  import bcd_gray_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [DIGIT_W*NDIG-1:0] req0_bcd,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [DIGIT_W*NDIG-1:0] req1_bcd,
  output logic                    req1_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DIGIT_W*NDIG-1:0] rsp_gray,
  output logic                    rsp_id,
  output logic                    rsp_err
);

  localparam int WORD_W = DIGIT_W * NDIG;
  localparam int CNT_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NDIG - 1);

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0]  gray_q, gray_d;
  logic               id_q, id_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT_W-1:0] digit_in;
  logic [DIGIT_W-1:0] digit_gray;
  logic               digit_over9;
  logic               grant1;

  assign digit_in = word_q[cnt_q*DIGIT_W +: DIGIT_W];

  bcd_gray_digit u_digit (
    .bcd_i   (digit_in),
    .gray_o  (digit_gray),
    .over9_o (digit_over9)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    word_d     = word_q;
    gray_d     = gray_q;
    id_d       = id_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // The pointed requester wins a tie; a lone valid requester always wins.
    grant1     = req1_valid && (!req0_valid || ptr_q);

    case (state_q)
      S_IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = !grant1;
          req1_ready = grant1;
          word_d     = grant1 ? req1_bcd : req0_bcd;
          id_d       = grant1;
          ptr_d      = !grant1;
          err_d      = 1'b0;
          cnt_d      = CNT_TOP;
          state_d    = S_CONV;
        end
      end
      S_CONV: begin
        gray_d[cnt_q*DIGIT_W +: DIGIT_W] = digit_gray;
        if (digit_over9) begin
          err_d = 1'b1;
        end
        if (cnt_q == '0) begin
          cnt_d   = CNT_TOP;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      word_q  <= '0;
      gray_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= CNT_TOP;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_gray  = gray_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule
